alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the combinational MIPS-style ALU. Accepts one operation at a time over a valid/ready input channel and returns a registered result plus flags over a valid/ready output channel. Single-cycle ops complete in one cycle; MULT/MULTU/DIV/DIVU run iteratively into internal HI/LO registers. Sits between the decode stage and writeback of the datapath.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, ≥ 8. Shift amount width SW = log2(WIDTH), derived internally.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation present
- in_ready  output  1  block accepts operation this cycle
- aluc  input  6  opcode
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- r  output  WIDTH  result
- zero, carry, negative, overflow, flag  output  1 each  status flags
- busy  output  1  iterative op in progress

## Operation
- Opcodes: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, LUI 001111, MFHI 010000, MFLO 010010, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
- Shifts: operand b shifted by a[SW-1:0]; V variants behave identically. carry = last bit shifted out (0 when amount 0).
- ADD/SUB: overflow = signed overflow; ADDU: carry = carry-out; SUBU: carry = borrow (a < b unsigned). Otherwise carry/overflow 0.
- SLT/SLTU: r = 1 if a < b (signed/unsigned) else 0; flag = r[0].
- LUI: r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
- MULT/MULTU: {HI,LO} = a × b (2·WIDTH, signed/unsigned); shift-add, one partial product per cycle.
- DIV/DIVU: LO = a / b, HI = a % b, restoring, one quotient bit per cycle; signed: quotient truncates toward zero, remainder takes sign of a. b = 0: LO = all ones, HI = a, flag = 1.
- Mult/div beat returns r = LO. MFHI/MFLO return HI/LO (single-cycle).
- For all ops: zero = (r == 0), negative = r[WIDTH-1]. flag = 0 except SLT/SLTU/divide-by-zero.
- Undefined opcode: r = 0, flag = 1, other flags per r.
- FSM: IDLE → (accept single-cycle op) RESULT; IDLE → (accept mult/div) ITER; ITER → RESULT after WIDTH iterations; RESULT → IDLE on out_ready, or directly to RESULT/ITER if a new op is accepted the same cycle.

## Timing
- Reset: out_valid = 0, r = 0, all flags 0, busy = 0, HI = LO = 0, FSM IDLE; in_ready rises 1 after reset deasserts.
- in_ready = !busy && (!out_valid || out_ready); transfer when in_valid && in_ready.
- Single-cycle op: out_valid asserted the cycle after acceptance (latency 1).
- MULT/MULTU/DIV/DIVU: busy asserted from the cycle after acceptance for WIDTH cycles; out_valid asserts at latency WIDTH+1.
- While out_valid && !out_ready, r and flags hold stable; no new op accepted.
- Back-to-back: result consumed and new op accepted in the same cycle gives 1 result/cycle for single-cycle ops.
- MFHI/MFLO accepted immediately after a mult/div result read the updated HI/LO.
- rst_n asserted mid-iteration aborts the op; HI/LO cleared; no output produced.

## Configuration
- ALU_DIV_EN defined: DIV/DIVU implemented as above.
- ALU_DIV_EN undefined: divider not built; DIV/DIVU treated as undefined opcodes (latency 1, r = 0, flag = 1, HI/LO unchanged).

## Test plan
- Reset, then ADD a=0x1c b=0x21 → r=0x3d, all flags 0, out_valid 1 cycle after accept.
- SUBU a=0x1c b=0x21 → r=0xFFFFFFFB, carry=1, negative=1; SLT same operands → r=1, flag=1.
- SLL a=0x1c b=0x21 → r=0x10000000, carry=0; LUI b=0x21 → r=0x00210000.
- MULT a=0x1c b=0x21 → out_valid at cycle 33, r=0x0000039C; MFHI → 0; MFLO → 0x39C; in_ready low throughout busy.
- DIV a=0xFFFFFFF9 b=2 → LO=0xFFFFFFFD, MFHI=0xFFFFFFFF; DIVU b=0 → r=0xFFFFFFFF, flag=1 (undefined-opcode response when ALU_DIV_EN off).
- Hold out_ready low 5 cycles during result → r stable, in_ready 0; assert rst_n low mid-MULT → out_valid 0, MFLO afterward returns 0.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result handshake bundle for alu_seq.
// master drives operations and out_ready; slave (the ALU) returns ready, result, flags and busy.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       aluc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             zero;
  logic             carry;
  logic             negative;
  logic             overflow;
  logic             flag;
  logic             busy;

  modport master (
    output in_valid, aluc, a, b, out_ready,
    input  in_ready, out_valid, r, zero, carry, negative, overflow, flag, busy
  );

  modport slave (
    input  in_valid, aluc, a, b, out_ready,
    output in_ready, out_valid, r, zero, carry, negative, overflow, flag, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked MIPS-style ALU; iterative shift-add multiply and restoring divide into HI/LO.
// Macro ALU_DIV_EN builds DIV/DIVU; without it they decode as undefined opcodes.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SW-1:0] LAST_ITER = SW'(WIDTH - 1);

  localparam logic [5:0] OP_ADD   = 6'b100000;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUB   = 6'b100010;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_SLTU  = 6'b101011;
  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLLV  = 6'b000100;
  localparam logic [5:0] OP_SRLV  = 6'b000110;
  localparam logic [5:0] OP_SRAV  = 6'b000111;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t           state_r;
  logic             ready_en_r;
  logic [WIDTH-1:0] r_r, hi_r, lo_r, work_lo_r, opnd_r;
  logic [WIDTH:0]   work_hi_r;
  logic [SW-1:0]    cnt_r;
  logic             zero_r, carry_r, negative_r, overflow_r, flag_r;
  logic             is_div_r, div0_r, neg_a_r, neg_b_r;

  logic             accept_s, is_div_op_s, is_iter_s, signed_op_s, lt_s, ltu_s;
  logic [SW-1:0]    sh_s;
  logic [WIDTH:0]   add_s, sub_s, shl_s, shr_s, sra_s;
  logic [WIDTH-1:0] res_s, mag_a_s, mag_b_s;
  logic             carry_s, ovf_s, flag_s;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_trial_s, nxt_hi_s;
  logic [WIDTH-1:0] nxt_lo_s, quo_s, rem_s, fin_hi_s, fin_lo_s;
  logic [2*WIDTH-1:0] prod_mag_s, prod_s;

  assign bus.out_valid = (state_r == ST_RESULT);
  assign bus.busy      = (state_r == ST_ITER);
  assign bus.in_ready  = ready_en_r && (state_r != ST_ITER) &&
                         ((state_r != ST_RESULT) || bus.out_ready);
  assign bus.r         = r_r;
  assign bus.zero      = zero_r;
  assign bus.carry     = carry_r;
  assign bus.negative  = negative_r;
  assign bus.overflow  = overflow_r;
  assign bus.flag      = flag_r;

  // Operation decode and operand magnitudes for the iterative units.
  always_comb begin
`ifdef ALU_DIV_EN
    is_div_op_s = (bus.aluc == OP_DIV) || (bus.aluc == OP_DIVU);
`else
    is_div_op_s = 1'b0;
`endif
    is_iter_s   = (bus.aluc == OP_MULT) || (bus.aluc == OP_MULTU) || is_div_op_s;
    signed_op_s = (bus.aluc == OP_MULT) || (bus.aluc == OP_DIV);
    mag_a_s     = (signed_op_s && bus.a[MSB]) ? -bus.a : bus.a;
    mag_b_s     = (signed_op_s && bus.b[MSB]) ? -bus.b : bus.b;
    accept_s    = bus.in_valid && bus.in_ready;
  end

  // Single-cycle datapath; shifts carry an extra bit so the last bit shifted out falls out naturally.
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    flag_s  = 1'b0;
    sh_s    = bus.a[SW-1:0];
    add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    sub_s   = {1'b0, bus.a} - {1'b0, bus.b};
    shl_s   = {1'b0, bus.b} << sh_s;
    shr_s   = {bus.b, 1'b0} >> sh_s;
    sra_s   = $signed({bus.b, 1'b0}) >>> sh_s;
    lt_s    = $signed(bus.a) < $signed(bus.b);
    ltu_s   = bus.a < bus.b;
    case (bus.aluc)
      OP_ADD: begin
        res_s = add_s[WIDTH-1:0];
        ovf_s = (bus.a[MSB] == bus.b[MSB]) && (add_s[MSB] != bus.a[MSB]);
      end
      OP_ADDU: begin
        res_s   = add_s[WIDTH-1:0];
        carry_s = add_s[WIDTH];
      end
      OP_SUB: begin
        res_s = sub_s[WIDTH-1:0];
        ovf_s = (bus.a[MSB] != bus.b[MSB]) && (sub_s[MSB] != bus.a[MSB]);
      end
      OP_SUBU: begin
        res_s   = sub_s[WIDTH-1:0];
        carry_s = sub_s[WIDTH];
      end
      OP_AND:  res_s = bus.a & bus.b;
      OP_OR:   res_s = bus.a | bus.b;
      OP_XOR:  res_s = bus.a ^ bus.b;
      OP_NOR:  res_s = ~(bus.a | bus.b);
      OP_SLT: begin
        res_s  = {{(WIDTH-1){1'b0}}, lt_s};
        flag_s = lt_s;
      end
      OP_SLTU: begin
        res_s  = {{(WIDTH-1){1'b0}}, ltu_s};
        flag_s = ltu_s;
      end
      OP_SLL, OP_SLLV: begin
        res_s   = shl_s[WIDTH-1:0];
        carry_s = shl_s[WIDTH];
      end
      OP_SRL, OP_SRLV: begin
        res_s   = shr_s[WIDTH:1];
        carry_s = shr_s[0];
      end
      OP_SRA, OP_SRAV: begin
        res_s   = sra_s[WIDTH:1];
        carry_s = sra_s[0];
      end
      OP_LUI:  res_s = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: res_s = hi_r;
      OP_MFLO: res_s = lo_r;
      OP_MULT, OP_MULTU: res_s = '0;
      default: flag_s = 1'b1;
    endcase
  end

  // One multiply/divide step plus the sign fix-up applied on the final step.
  always_comb begin
    mul_sum_s   = work_hi_r + (work_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {work_hi_r[WIDTH-1:0], work_lo_r[MSB]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    if (is_div_r) begin
      if (!div_trial_s[WIDTH]) begin
        nxt_hi_s = div_trial_s;
        nxt_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi_s = div_shift_s;
        nxt_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi_s = {1'b0, mul_sum_s[WIDTH:1]};
      nxt_lo_s = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
    end
    prod_mag_s = {nxt_hi_s[WIDTH-1:0], nxt_lo_s};
    prod_s     = (neg_a_r ^ neg_b_r) ? -prod_mag_s : prod_mag_s;
    // Divide by zero still runs the full loop so latency is operand-independent.
    quo_s      = div0_r ? {WIDTH{1'b1}} : ((neg_a_r ^ neg_b_r) ? -nxt_lo_s : nxt_lo_s);
    rem_s      = neg_a_r ? -nxt_hi_s[WIDTH-1:0] : nxt_hi_s[WIDTH-1:0];
    fin_hi_s   = is_div_r ? rem_s : prod_s[2*WIDTH-1:WIDTH];
    fin_lo_s   = is_div_r ? quo_s : prod_s[WIDTH-1:0];
  end

  // Control FSM with all registered state, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      ready_en_r <= 1'b0;
      r_r        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      work_hi_r  <= '0;
      work_lo_r  <= '0;
      opnd_r     <= '0;
      cnt_r      <= '0;
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      negative_r <= 1'b0;
      overflow_r <= 1'b0;
      flag_r     <= 1'b0;
      is_div_r   <= 1'b0;
      div0_r     <= 1'b0;
      neg_a_r    <= 1'b0;
      neg_b_r    <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      case (state_r)
        ST_IDLE, ST_RESULT: begin
          if (accept_s) begin
            if (is_iter_s) begin
              work_hi_r <= '0;
              work_lo_r <= mag_a_s;
              opnd_r    <= mag_b_s;
              cnt_r     <= '0;
              is_div_r  <= is_div_op_s;
              div0_r    <= (bus.b == '0);
              neg_a_r   <= signed_op_s && bus.a[MSB];
              neg_b_r   <= signed_op_s && bus.b[MSB];
              state_r   <= ST_ITER;
            end else begin
              r_r        <= res_s;
              zero_r     <= (res_s == '0);
              carry_r    <= carry_s;
              negative_r <= res_s[MSB];
              overflow_r <= ovf_s;
              flag_r     <= flag_s;
              state_r    <= ST_RESULT;
            end
          end else if ((state_r == ST_RESULT) && bus.out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_ITER: begin
          work_hi_r <= nxt_hi_s;
          work_lo_r <= nxt_lo_s;
          cnt_r     <= cnt_r + {{(SW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_ITER) begin
            hi_r       <= fin_hi_s;
            lo_r       <= fin_lo_s;
            r_r        <= fin_lo_s;
            zero_r     <= (fin_lo_s == '0);
            carry_r    <= 1'b0;
            negative_r <= fin_lo_s[MSB];
            overflow_r <= 1'b0;
            flag_r     <= is_div_r && div0_r;
            state_r    <= ST_RESULT;
          end else begin
            state_r <= ST_ITER;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule
